// File: rtl/serialtx_fifo_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serialtx_fifo_if -- pipelined Wishbone (stall/ack) register port. Rev 1.0
// ---------------------------------------------------------------------------
interface serialtx_fifo_if;
  logic [31:0] wb_addr;
  logic [31:0] wb_data_w;
  logic [31:0] wb_data_r;
  logic        wb_we;
  logic        wb_stb;
  logic        wb_cyc;
  logic        wb_ack;
  logic        wb_stall;

  modport master (
    output wb_addr, wb_data_w, wb_we, wb_stb, wb_cyc,
    input  wb_data_r, wb_ack, wb_stall
  );

  modport slave (
    input  wb_addr, wb_data_w, wb_we, wb_stb, wb_cyc,
    output wb_data_r, wb_ack, wb_stall
  );
endinterface
`default_nettype wire

// File: rtl/serialtx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serialtx_fifo -- Wishbone-fed transmit FIFO and configurable UART shifter.
// Revision: 1.0
// ---------------------------------------------------------------------------
module serialtx_fifo #(
  parameter int FRAME      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIVIDE     = 868,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  serialtx_fifo_if.slave   wb,
  output logic             uart_tx
);
  localparam int c_aw    = $clog2(FIFO_DEPTH);
  localparam int c_idx_w = $clog2(FRAME);
  localparam logic [c_aw:0]      c_depth    = (c_aw + 1)'(FIFO_DEPTH);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(FRAME - 1);
  localparam logic               c_last_stp = 1'(STOP_BITS - 1);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_start  = 3'd1;
  localparam logic [2:0] c_st_data   = 3'd2;
  localparam logic [2:0] c_st_parity = 3'd3;
  localparam logic [2:0] c_st_stop   = 3'd4;

  localparam logic [1:0] c_a_txdata  = 2'd0;
  localparam logic [1:0] c_a_status  = 2'd1;
  localparam logic [1:0] c_a_divisor = 2'd2;
  localparam logic [1:0] c_a_count   = 2'd3;

  logic [FRAME-1:0]   r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]    r_wr_ptr, r_rd_ptr;
  logic [c_aw:0]      r_level;
  logic [2:0]         r_state;
  logic [15:0]        r_bit_cnt, r_cur_div, r_div;
  logic [FRAME-1:0]   r_shift;
  logic               r_par, r_stop, r_tx, r_ack;
  logic [c_idx_w-1:0] r_idx;
  logic [31:0]        r_count, r_rdata, w_rd_mux;

  logic w_full, w_empty, w_accept, w_push, w_pop, w_div_wr, w_cnt_clr;
  logic w_bit_end, w_frame_end, w_busy, w_head_par, w_unused;
  logic [1:0]       w_sel;
  logic [FRAME-1:0] w_head;

  assign w_full      = (r_level == c_depth);
  assign w_empty     = (r_level == '0);
  assign w_sel       = wb.wb_addr[3:2];
  assign w_accept    = wb.wb_cyc && wb.wb_stb && !w_full;
  assign w_push      = w_accept && wb.wb_we && (w_sel == c_a_txdata);
  assign w_div_wr    = w_accept && wb.wb_we && (w_sel == c_a_divisor) && (wb.wb_data_w[15:1] != '0);
  assign w_cnt_clr   = w_accept && wb.wb_we && (w_sel == c_a_count);
  assign w_busy      = (r_state != c_st_idle);
  assign w_bit_end   = (r_bit_cnt == r_cur_div - 16'd1);
  assign w_frame_end = (r_state == c_st_stop) && w_bit_end && (r_stop == c_last_stp);
  // A frame end with data waiting pops immediately so the next start follows the stop bit.
  assign w_pop       = !w_empty && ((r_state == c_st_idle) || w_frame_end);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_par  = (^w_head) ^ (PARITY == 2);
  assign w_unused    = &{1'b0, wb.wb_addr[31:4], wb.wb_addr[1:0], wb.wb_data_w[31:16]};

  assign wb.wb_stall  = wb.wb_cyc && w_full;
  assign wb.wb_ack    = r_ack;
  assign wb.wb_data_r = r_rdata;
  assign uart_tx      = r_tx;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wb.wb_data_w[FRAME-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (c_aw + 1)'(1);
        2'b01:   r_level <= r_level - (c_aw + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_st_idle;
      r_bit_cnt <= '0;
      r_cur_div <= 16'(DIVIDE);
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_idx     <= '0;
      r_stop    <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      if (r_state != c_st_idle) r_bit_cnt <= w_bit_end ? 16'd0 : r_bit_cnt + 16'd1;
      // Frame load: divisor is sampled here, so later writes only affect the next frame.
      if (w_pop) begin
        r_state   <= c_st_start;
        r_bit_cnt <= '0;
        r_cur_div <= r_div;
        r_shift   <= w_head;
        r_par     <= w_head_par;
        r_tx      <= 1'b0;
      end else begin
        case (r_state)
          c_st_idle: r_tx <= 1'b1;
          c_st_start: if (w_bit_end) begin
            r_state <= c_st_data;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
          end
          c_st_data: if (w_bit_end) begin
            if (r_idx == c_last_idx) begin
              r_stop <= 1'b0;
              if (PARITY != 0) begin
                r_state <= c_st_parity;
                r_tx    <= r_par;
              end else begin
                r_state <= c_st_stop;
                r_tx    <= 1'b1;
              end
            end else begin
              r_idx   <= r_idx + c_idx_w'(1);
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end
          c_st_parity: if (w_bit_end) begin
            r_state <= c_st_stop;
            r_tx    <= 1'b1;
          end
          c_st_stop: if (w_bit_end) begin
            if (r_stop == c_last_stp) r_state <= c_st_idle;
            else                      r_stop  <= 1'b1;
            r_tx <= 1'b1;
          end
          default: begin
            r_state <= c_st_idle;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (w_sel)
      c_a_status:  w_rd_mux = {13'd0, w_empty, w_full, w_busy, 16'(r_level)};
      c_a_divisor: w_rd_mux = {16'd0, r_div};
      c_a_count:   w_rd_mux = r_count;
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= 16'(DIVIDE);
      r_count <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_div_wr) r_div <= wb.wb_data_w[15:0];
      if (w_cnt_clr)        r_count <= '0;
      else if (w_frame_end) r_count <= r_count + 32'd1;
      r_ack   <= w_accept;
      r_rdata <= (w_accept && !wb.wb_we) ? w_rd_mux : 32'd0;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_serialtx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serialtx_fifo -- scoreboard bench with a cycle-timeline reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_serialtx_fifo;
  localparam int FRAME = 8, DEPTH = 4, DIVIDE = 4, PARITY = 1, STOP_BITS = 1;
  localparam int NBITS = 1 + FRAME + ((PARITY != 0) ? 1 : 0) + STOP_BITS;

  typedef struct { int cyc; bit we; logic [1:0] sel; } acc_t;
  typedef struct { int cyc; bit chk; logic [31:0] v; } rsp_t;

  logic clk = 1'b0, rst_n = 1'b0, tx, tx2;
  int   t = 0, checks = 0, errors = 0, last_acc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) t <= t + 1;

  serialtx_fifo_if bus();
  serialtx_fifo_if bus2();
  serialtx_fifo #(.FRAME(FRAME), .FIFO_DEPTH(DEPTH), .DIVIDE(DIVIDE), .PARITY(PARITY), .STOP_BITS(STOP_BITS))
    u_dut (.clk(clk), .rst_n(rst_n), .wb(bus), .uart_tx(tx));
  serialtx_fifo #(.FRAME(7), .FIFO_DEPTH(2), .DIVIDE(3), .PARITY(2), .STOP_BITS(2))
    u_dut2 (.clk(clk), .rst_n(rst_n), .wb(bus2), .uart_tx(tx2));

  // Timeline model: every event is a cycle number; register contents are derived from history.
  int pend_a[$], push_cyc[$], start_cyc[$], end_cyc[$], clr_cyc[$], divw_c[$], divw_v[$];
  logic [7:0] pend_d[$];
  acc_t acc_q[$];
  bit   mon_en = 0, active = 0;
  int   prev_end = -100, f_start = 0, f_end = 0, f_div = 1;
  logic [NBITS-1:0] f_bits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, t);
    end
  endtask

  function automatic int div_at(int c);
    int v = DIVIDE;
    foreach (divw_c[i]) if (divw_c[i] + 1 <= c) v = divw_v[i];
    return v;
  endfunction
  function automatic int count_at(int r);
    int w = -1, n = 0;
    foreach (clr_cyc[i]) if (clr_cyc[i] < r && clr_cyc[i] > w) w = clr_cyc[i];
    foreach (end_cyc[i]) if (end_cyc[i] > w && end_cyc[i] < r) n++;
    return n;
  endfunction
  function automatic int level_at(int r);
    int n = 0;
    foreach (push_cyc[i])  if (push_cyc[i] < r)   n++;
    foreach (start_cyc[i]) if (start_cyc[i] <= r) n--;
    return n;
  endfunction
  function automatic bit busy_at(int r);
    foreach (start_cyc[i]) if (start_cyc[i] <= r && r <= end_cyc[i]) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic [31:0] status_at(int r);
    int l = level_at(r);
    return {13'd0, l == 0, l == DEPTH, busy_at(r), 16'(l)};
  endfunction
  function automatic logic [NBITS-1:0] frame_bits(logic [7:0] d);
    logic [NBITS-1:0] b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < FRAME; i++) b[1 + i] = d[i];
    if (PARITY != 0) b[1 + FRAME] = (^d) ^ (PARITY == 2);
    return b;
  endfunction

  task automatic model_reset();
    pend_a.delete(); pend_d.delete(); push_cyc.delete(); start_cyc.delete(); end_cyc.delete();
    clr_cyc.delete(); divw_c.delete(); divw_v.delete(); acc_q.delete();
    active = 0; prev_end = -100;
  endtask

  always @(posedge clk) begin : mon
    int s;
    logic ex;
    acc_t a;
    #1;
    if (mon_en) begin
      if (active && t > f_end) begin active = 0; prev_end = f_end; end
      if (!active && pend_a.size() > 0) begin
        s = (prev_end + 1 > pend_a[0] + 2) ? prev_end + 1 : pend_a[0] + 2;
        if (t == s) begin
          f_div = div_at(s - 1); f_start = s; f_end = s + NBITS * f_div - 1;
          f_bits = frame_bits(pend_d[0]); active = 1;
          start_cyc.push_back(s); end_cyc.push_back(f_end);
          void'(pend_a.pop_front()); void'(pend_d.pop_front());
        end
      end
      ex = active ? f_bits[(t - f_start) / f_div] : 1'b1;
      check("uart_tx", 32'(tx), 32'(ex));
      if (bus.wb_cyc) check("wb_stall", 32'(bus.wb_stall), 32'(level_at(t) == DEPTH));
      if (acc_q.size() > 0 && acc_q[0].cyc == t - 1) begin
        a = acc_q.pop_front();
        check("wb_ack", 32'(bus.wb_ack), 32'd1);
        if (!a.we) case (a.sel)
          2'd0: check("rd_txdata", bus.wb_data_r, 32'd0);
          2'd1: check("rd_status", bus.wb_data_r, status_at(t - 1));
          2'd2: check("rd_divisor", bus.wb_data_r, 32'(div_at(t - 1)));
          default: check("rd_count", bus.wb_data_r, 32'(count_at(t - 1)));
        endcase
      end else check("wb_ack_idle", 32'(bus.wb_ack), 32'd0);
    end
  end

  task automatic bus_idle();
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
  endtask

  task automatic bus_op(input bit we, input logic [1:0] sel, input logic [31:0] data);
    int guard = 0;
    logic [31:0] r = $urandom();
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = we;
    bus.wb_addr = {r[31:4], sel, r[1:0]}; bus.wb_data_w = data;
    #1;
    while (bus.wb_stall) begin
      guard++;
      if (guard > 2000) begin
        checks++; errors++; $display("FAIL stall_timeout: stall held %0d cycles, required release", guard);
        return;
      end
      @(negedge clk); #1;
    end
    last_acc = t;
    acc_q.push_back('{t, we, sel});
    if (we && sel == 2'd0) begin pend_a.push_back(t); pend_d.push_back(data[7:0]); push_cyc.push_back(t); end
    if (we && sel == 2'd2 && data[15:0] > 16'd1) begin divw_c.push_back(t); divw_v.push_back(int'(data[15:0])); end
    if (we && sel == 2'd3) clr_cyc.push_back(t);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (pend_a.size() > 0 || active || acc_q.size() > 0) begin
      guard++;
      if (guard > 5000) begin
        checks++; errors++; $display("FAIL idle_timeout: transmitter still busy, required idle");
        return;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic read_all();
    bus_op(0, 2'd1, 0); bus_op(0, 2'd3, 0); bus_op(0, 2'd2, 0); bus_op(0, 2'd0, 0);
    bus_idle();
  endtask

  // Second configuration: 7 data bits, odd parity, two stop bits, divisor 3.
  rsp_t q2[$];
  bit   mon2_en = 0, done2 = 0;
  int   s2 = 32'h7fff0000, a2 = 0;
  logic [10:0] bits2 = 11'b110_1111_1110;

  always @(posedge clk) begin : mon2
    logic ex;
    rsp_t e;
    #1;
    if (mon2_en) begin
      ex = (t >= s2 && t < s2 + 33) ? bits2[(t - s2) / 3] : 1'b1;
      check("dut2_uart_tx", 32'(tx2), 32'(ex));
      if (q2.size() > 0 && q2[0].cyc == t - 1) begin
        e = q2.pop_front();
        check("dut2_ack", 32'(bus2.wb_ack), 32'd1);
        if (e.chk) check("dut2_status", bus2.wb_data_r, e.v);
      end else check("dut2_ack_idle", 32'(bus2.wb_ack), 32'd0);
    end
  end

  initial begin : stim2
    int lvl;
    bus2.wb_cyc = 1'b0; bus2.wb_stb = 1'b0; bus2.wb_we = 1'b0; bus2.wb_addr = '0; bus2.wb_data_w = '0;
    wait (rst_n === 1'b1);
    @(negedge clk);
    mon2_en = 1;
    bus2.wb_cyc = 1'b1; bus2.wb_stb = 1'b1; bus2.wb_we = 1'b1; bus2.wb_addr = 32'h0; bus2.wb_data_w = 32'h7F;
    #1;
    check("dut2_stall", 32'(bus2.wb_stall), 32'd0);
    a2 = t; s2 = a2 + 2;
    q2.push_back('{a2, 1'b0, 32'd0});
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      bus2.wb_we = 1'b0; bus2.wb_addr = 32'h4;
      lvl = (t == a2 + 1) ? 1 : 0;
      q2.push_back('{t, 1'b1, {13'd0, lvl == 0, 1'b0, (t >= a2 + 2 && t <= a2 + 34), 16'(lvl)}});
      @(negedge clk);
    end
    bus2.wb_cyc = 1'b0; bus2.wb_stb = 1'b0;
    repeat (3) @(negedge clk);
    check("dut2_pending", 32'(q2.size()), 32'd0);
    mon2_en = 0; done2 = 1;
  end

  initial begin : stim
    int e, x, d, n;
    logic [31:0] r;
    bus_idle(); bus.wb_addr = '0; bus.wb_data_w = '0;
    repeat (2) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_ack", 32'(bus.wb_ack), 32'd0);
    check("reset_data_r", bus.wb_data_r, 32'd0);
    rst_n = 1'b1; mon_en = 1;
    @(negedge clk);
    read_all();

    bus_op(1, 2'd0, 32'h55); bus_idle(); wait_idle(); read_all();

    for (int i = 1; i <= 6; i++) bus_op(1, 2'd0, 32'(i));
    bus_idle(); wait_idle(); read_all();

    bus_op(1, 2'd0, 32'h11); bus_op(1, 2'd0, 32'h22); bus_idle();
    repeat (8) @(negedge clk);
    bus_op(1, 2'd2, 32'd8); bus_op(0, 2'd2, 0); bus_op(1, 2'd2, 32'd1); bus_op(0, 2'd2, 0);
    bus_idle(); wait_idle();
    bus_op(0, 2'd2, 0); bus_op(1, 2'd2, 32'd4); bus_idle(); wait_idle();

    bus_op(1, 2'd0, 32'hA5); bus_idle();
    e = last_acc + 2 + NBITS * div_at(last_acc + 1) - 1;
    while (t < e) @(negedge clk);
    bus_op(1, 2'd3, 0); bus_op(0, 2'd3, 0); bus_idle(); wait_idle();

    bus_op(1, 2'd0, 32'h00); bus_idle();
    x = last_acc + 2 + 4 * div_at(last_acc + 1) + 1;
    while (t < x - 1) @(negedge clk);
    bus_op(0, 2'd1, 0); bus_idle();
    check("pre_reset_tx", 32'(tx), 32'd0);
    check("pre_reset_ack", 32'(bus.wb_ack), 32'd1);
    mon_en = 0; rst_n = 1'b0;
    #1;
    check("async_reset_tx", 32'(tx), 32'd1);
    check("async_reset_ack", 32'(bus.wb_ack), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1; mon_en = 1;
    @(negedge clk);
    read_all();

    for (int i = 0; i < 160; i++) begin
      n = $urandom_range(0, 11);
      r = $urandom();
      if (n <= 4)       bus_op(1, 2'd0, r);
      else if (n == 5)  bus_op(1, 2'd2, {r[31:16], 16'($urandom_range(0, 6))});
      else if (n == 6)  bus_op(1, 2'd3, r);
      else if (n == 7)  bus_op(1, 2'd1, r);
      else if (n <= 9)  bus_op(0, 2'($urandom_range(0, 3)), r);
      else begin
        bus_idle();
        d = $urandom_range(1, 40);
        repeat (d) @(negedge clk);
      end
    end
    bus_idle(); wait_idle(); read_all(); wait_idle();

    n = 0;
    while (!done2 && n < 2000) begin n++; @(negedge clk); end
    check("dut2_done", 32'(done2), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/serialtx_fifo.md
Name: serialtx_fifo

Overview:
Parametrised successor to the single-byte serial transmitter. It takes bytes from a Wishbone (pipelined, stall/ack) register interface into a transmit FIFO and shifts them out on uart_tx. Frame format is configurable: data width, optional parity and 1/2 stop bits. The bit-period divisor is runtime-programmable, and the block keeps a sent-frame counter. It sits on the peripheral Wishbone bus beside the other memory-mapped I/O blocks.

Parameters:
FRAME, 8, data bits per frame (5..9), LSB first
FIFO_DEPTH, 4, transmit FIFO entries (power of 2, >=2)
DIVIDE, 868, reset value of the divisor register (clocks per bit, >=2)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
uart_tx  out  1  serial output, idle high
wb_addr  in  32  byte address; only [3:2] decoded
wb_data_w  in  32  write data
wb_data_r  out  32  read data, valid when wb_ack=1
wb_we  in  1  write enable
wb_stb  in  1  strobe
wb_cyc  in  1  bus cycle
wb_ack  out  1  acknowledge
wb_stall  out  1  stall

Behaviour:
- Reset (rst_n low, async): uart_tx=1, wb_ack=0, wb_data_r=0, FIFO empty, shifter IDLE, divisor=DIVIDE, COUNT=0. Takes effect immediately, including mid-frame; no partial frame resumes.
- wb_stall = wb_cyc && FIFO full (combinational). Accept = wb_cyc && wb_stb && !wb_stall. Each accepted request gives wb_ack=1 exactly one cycle later, with registered wb_data_r. No ack without a prior accept. wb_ack=0 whenever no request was accepted the previous cycle.
- Register map (wb_addr[3:2]):
  - 0 TXDATA: write pushes wb_data_w[FRAME-1:0]; read returns 0.
  - 1 STATUS (RO): [15:0] FIFO level, [16] shifter busy, [17] full, [18] empty, rest 0.
  - 2 DIVISOR (RW): [15:0]. Writes of 0 or 1 are ignored. A new value takes effect at the next frame start; the current frame finishes at the old rate.
  - 3 COUNT: read returns frames completed (32-bit, wraps at 2^32). Any write clears it to 0. Clear wins over a same-cycle increment.
  - Writes to STATUS are acked and ignored.
- Shifter states: IDLE -> START -> DATA (FRAME bits, index 0..FRAME-1) -> PARITY (only if PARITY!=0) -> STOP (STOP_BITS periods) -> IDLE or START.
- Each non-IDLE bit lasts exactly divisor clocks, counted by a bit-period counter that resets at each bit boundary.
- uart_tx by state: IDLE=1, START=0, DATA=data[index], PARITY = XOR of data bits (even) or its inverse (odd), STOP=1.
- Pop rules:
  - In IDLE with FIFO non-empty: pop that cycle and latch data and divisor; START begins the next cycle.
  - At the last clock of the final stop period: COUNT increments. If the FIFO is non-empty, pop in the same cycle and go straight to START (no idle gap). Otherwise go to IDLE.
- Latency: TXDATA write accepted in cycle N -> entry visible at N+1 -> popped at N+1 if idle -> uart_tx falls at N+2.
- FIFO: push and pop in the same cycle are both performed, level unchanged. Pointers wrap modulo FIFO_DEPTH. A push when full is impossible because of stall. A pop when empty never occurs.
- Busy (STATUS[16]) = shifter not IDLE.

Test Plan:
- DIVIDE=4, FRAME=8, PARITY=1, STOP_BITS=1; write TXDATA 0x55 -> uart_tx = 0,1,0,1,0,1,0,1,0,0(parity),1, each 4 clocks, 44 clocks total. Falling edge 2 cycles after accept. COUNT reads 1 afterwards.
- FIFO_DEPTH=4; 6 back-to-back TXDATA writes 0x01..0x06 -> wb_stall asserts once level=4 and releases on a pop. Exactly 6 acks, one cycle after each accept. Six frames with no idle cycle between stop and next start. COUNT=6, STATUS[18]=1 at end.
- Write DIVISOR=8 during the data bits of frame 1 with frame 2 queued -> frame 1 bits stay 4 clocks, frame 2 bits are 8 clocks. DIVISOR reads back 8. Then write DIVISOR=1 -> reads back 8.
- Deassert rst_n during data bit 3 -> uart_tx=1 and wb_ack=0 asynchronously. After release: STATUS level 0, empty=1, busy=0; COUNT 0; DIVISOR reads 4.
- Write COUNT on the exact cycle a frame completes -> COUNT reads 0, not 1.
- PARITY=2, STOP_BITS=2, FRAME=7; send 0x7F -> start 0, seven 1s, parity 0, stop high for 2 periods. STATUS busy=1 throughout and 0 the cycle after.
